// File: rtl/trace_dump_pkg.sv
// Shared types and constants for the trace dump controller.
// Optional header byte build: define TRACE_DUMP_HDR_EN.
package trace_dump_pkg;

  localparam logic [1:0] CH_ILLEGAL = 2'd3;
  localparam logic [7:0] HDR_BASE   = 8'hA0;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LAT,
    SEND,
    WAIT_TX,
    FIN,
    HDR
  } dump_state_t;

  function automatic logic [2:0] chan_onehot(input logic [1:0] c);
    return 3'b001 << c;
  endfunction

endpackage

// File: rtl/trace_addr_seq.sv
// Circular read address and byte counter for one trace dump.
// Loads oldest sample (base+1) and flags the final byte of a full pass.
module trace_addr_seq
  import trace_dump_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          inc_i,
  input  logic [AW-1:0] base_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      addr_d = base_i + AW'(1);
      cnt_d  = '0;
    end else if (inc_i) begin
      addr_d = addr_q + AW'(1);
      cnt_d  = cnt_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q == {1'b0, {AW{1'b1}}});

endmodule

// File: rtl/trace_dump_ctrl.sv
// Streams a captured trace from one channel RAM to the UART, oldest first.
// Define TRACE_DUMP_HDR_EN to prefix each dump with a channel header byte.
module trace_dump_ctrl
  import trace_dump_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dump_start,
  input  logic [1:0]    dump_chan,
  input  logic          dump_abort,
  input  logic          cap_busy,
  input  logic [AW-1:0] trace_end,
  output logic          ram_en,
  output logic [2:0]    ram_sel,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] rdata_ch1,
  input  logic [DW-1:0] rdata_ch2,
  input  logic [DW-1:0] rdata_ch3,
  output logic [DW-1:0] tx_data,
  output logic          trmt,
  input  logic          tx_done,
  output logic          dump_busy,
  output logic          dump_done,
  output logic          dump_err
);

  dump_state_t   state_q, state_d;
  logic [2:0]    sel_q, sel_d;
  logic [DW-1:0] txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          load, inc, last;
  logic          accept;

`ifdef TRACE_DUMP_HDR_EN
  logic          hdr_q, hdr_d;
  logic [1:0]    chan_q, chan_d;
`endif

  assign accept = dump_start & ~cap_busy
                & (dump_chan != CH_ILLEGAL);

  trace_addr_seq #(.AW(AW)) u_seq (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (load),
    .inc_i  (inc),
    .base_i (trace_end),
    .addr_o (ram_addr),
    .last_o (last)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    txd_d     = txd_q;
    busy_d    = busy_q;
    err_d     = 1'b0;
    load      = 1'b0;
    inc       = 1'b0;
    ram_en    = 1'b0;
    trmt      = 1'b0;
    dump_done = 1'b0;
`ifdef TRACE_DUMP_HDR_EN
    hdr_d     = hdr_q;
    chan_d    = chan_q;
`endif
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          if (accept) begin
            sel_d  = chan_onehot(dump_chan);
            load   = 1'b1;
            busy_d = 1'b1;
`ifdef TRACE_DUMP_HDR_EN
            chan_d  = dump_chan;
            state_d = HDR;
`else
            state_d = RD;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RD: begin
        ram_en  = 1'b1;
        state_d = LAT;
      end
      LAT: begin
        unique case (1'b1)
          sel_q[0]: txd_d = rdata_ch1;
          sel_q[1]: txd_d = rdata_ch2;
          sel_q[2]: txd_d = rdata_ch3;
          default:  txd_d = txd_q;
        endcase
        state_d = SEND;
      end
      SEND: begin
        trmt    = 1'b1;
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done) begin
`ifdef TRACE_DUMP_HDR_EN
          if (hdr_q) begin
            hdr_d   = 1'b0;
            state_d = RD;
          end else begin
            inc     = 1'b1;
            state_d = last ? FIN : RD;
          end
`else
          inc     = 1'b1;
          state_d = last ? FIN : RD;
`endif
        end
      end
      FIN: begin
        dump_done = 1'b1;
        busy_d    = 1'b0;
        sel_d     = 3'b000;
        state_d   = IDLE;
      end
      HDR: begin
`ifdef TRACE_DUMP_HDR_EN
        txd_d   = DW'(HDR_BASE | {6'd0, chan_q});
        hdr_d   = 1'b1;
        state_d = SEND;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    // Abort beats every in-flight action, including a coincident tx_done.
    if (dump_abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      err_d     = 1'b1;
      busy_d    = 1'b0;
      sel_d     = 3'b000;
      inc       = 1'b0;
      ram_en    = 1'b0;
      trmt      = 1'b0;
      dump_done = 1'b0;
`ifdef TRACE_DUMP_HDR_EN
      hdr_d     = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      txd_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef TRACE_DUMP_HDR_EN
      hdr_q   <= 1'b0;
      chan_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
`ifdef TRACE_DUMP_HDR_EN
      hdr_q   <= hdr_d;
      chan_q  <= chan_d;
`endif
    end
  end

  assign ram_sel   = sel_q;
  assign tx_data   = txd_q;
  assign dump_busy = busy_q;
  assign dump_err  = err_q;

endmodule
